// File: rtl/risc_mem_pkg.sv
// risc_mem_pkg
//   Shared types and constants for the unified-memory arbitration logic.
//   - DATA_W / ADDR_W : default memory data and address widths
//   - owner_e         : identifies which requester owns (or wins) the port
//   - arb_state_e     : arbiter FSM state
package risc_mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_D    = 2'd2,
        OWN_I    = 2'd3
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational priority selector for a three-requester memory port.
//   Priority is loader > data > fetch, except that a starving fetch beats
//   data (never the loader). A requester named by i_exclude is ignored,
//   which lets the owner that is completing this cycle step aside while
//   its req is still high.
// Ports:
//   i_reqs    in  3        {loader, data, fetch} request bits
//   i_exclude in  owner_e  requester to ignore (OWN_NONE = nobody)
//   i_starve  in  1        fetch has waited through the allowed data streak
//   o_owner   out owner_e  winner, OWN_NONE when nothing eligible
module mem_arb_pick
    import risc_mem_pkg::*;
(
    input  logic [2:0] i_reqs,
    input  owner_e     i_exclude,
    input  logic       i_starve,
    output owner_e     o_owner
);

    logic w_ld;
    logic w_d;
    logic w_i;

    always_comb begin
        w_ld = i_reqs[2] && (i_exclude != OWN_LD);
        w_d  = i_reqs[1] && (i_exclude != OWN_D);
        w_i  = i_reqs[0] && (i_exclude != OWN_I);

        o_owner = OWN_NONE;
        if (w_ld) begin
            o_owner = OWN_LD;
        end else if (w_i && i_starve) begin
            o_owner = OWN_I;
        end else if (w_d) begin
            o_owner = OWN_D;
        end else if (w_i) begin
            o_owner = OWN_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory with fixed read latency MEM_LAT among the
//   boot/debug loader (ld_*), the Mem-stage data port (d_*) and the IF-stage
//   fetch (i_*). One access is outstanding at a time.
//
//   Handshake (all three requesters): a requester raises *_req with its
//   address/we/wdata stable and keeps them until it sees *_done. *_gnt
//   pulses in the cycle the access is put on the memory (mem_en high,
//   memory controls driven combinationally from the winner). *_done pulses
//   for exactly one cycle MEM_LAT cycles after *_gnt, with rdata carrying
//   mem_rdata in that cycle; rdata is 0 otherwise. A req dropped before its
//   grant is simply withdrawn.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   ld_req/we/addr/wdata       loader request;  ld_gnt, ld_done
//   d_req/we/addr/wdata        data request;    d_gnt, d_done
//   i_req/addr                 fetch request;   i_gnt, i_done
//   rdata                      shared read return, valid with any *_done
//   mem_en/we/addr/wdata       memory strobe and controls
//   mem_rdata                  memory read data, MEM_LAT cycles after mem_en
//   stall_if, stall_mem        pipeline stalls for fetch / data side
//   o_dbg_state                {FSM state, current owner}
module mem_port_arbiter #(
    parameter int DATA_W     = risc_mem_pkg::DATA_W,
    parameter int ADDR_W     = risc_mem_pkg::ADDR_W,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [2:0]        o_dbg_state
);

    import risc_mem_pkg::*;

    localparam int          SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);
    localparam logic [2:0]  CNT_LOAD   = 3'(MEM_LAT);

    arb_state_e    r_state;
    owner_e        r_owner;
    logic [2:0]    r_cnt;
    logic [SW-1:0] r_streak;

    logic   w_last;
    logic   w_arb_en;
    logic   w_starve;
    owner_e w_exclude;
    owner_e w_pick;
    owner_e w_win;

    // Last BUSY cycle: the owner's data is on mem_rdata and the port can be
    // re-issued in the same cycle.
    assign w_last    = (r_state == ST_BUSY) && (r_cnt == 3'd1);
    // Gating with reset keeps mem_en low the instant reset rises, even if a
    // requester is still holding its req.
    assign w_arb_en  = !reset && ((r_state == ST_IDLE) || w_last);
    assign w_exclude = w_last ? r_owner : OWN_NONE;
    assign w_starve  = (r_streak == STREAK_MAX) && i_req;

    mem_arb_pick u_pick (
        .i_reqs    ({ld_req, d_req, i_req}),
        .i_exclude (w_exclude),
        .i_starve  (w_starve),
        .o_owner   (w_pick)
    );

    assign w_win = w_arb_en ? w_pick : OWN_NONE;

    assign ld_gnt = (w_win == OWN_LD);
    assign d_gnt  = (w_win == OWN_D);
    assign i_gnt  = (w_win == OWN_I);
    assign mem_en = (w_win != OWN_NONE);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (w_win)
            OWN_LD: begin
                mem_we    = ld_we;
                mem_addr  = ld_addr;
                mem_wdata = ld_wdata;
            end
            OWN_D: begin
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            OWN_I: begin
                mem_addr  = i_addr;
            end
            default: ;
        endcase
    end

    assign ld_done = w_last && (r_owner == OWN_LD);
    assign d_done  = w_last && (r_owner == OWN_D);
    assign i_done  = w_last && (r_owner == OWN_I);
    assign rdata   = w_last ? mem_rdata : '0;

    assign stall_if    = i_req & ~i_done;
    assign stall_mem   = d_req & ~d_done;
    assign o_dbg_state = {r_state, r_owner};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= OWN_NONE;
            r_cnt    <= 3'd0;
            r_streak <= '0;
        end else begin
            if (w_win != OWN_NONE) begin
                r_state <= ST_BUSY;
                r_owner <= w_win;
                r_cnt   <= CNT_LOAD;
            end else if (w_last) begin
                r_state <= ST_IDLE;
                r_owner <= OWN_NONE;
                r_cnt   <= 3'd0;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - 3'd1;
            end

            // Streak of data grants taken while fetch is waiting; loader
            // grants leave it unchanged.
            if (!i_req || (w_win == OWN_I)) begin
                r_streak <= '0;
            end else if ((w_win == OWN_D) && (r_streak != STREAK_MAX)) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        ld_req, ld_we;
    logic [15:0] ld_addr, ld_wdata;
    logic        d_req, d_we;
    logic [15:0] d_addr, d_wdata;
    logic        i_req;
    logic [15:0] i_addr;

    logic        a_ld_gnt, a_ld_done, a_d_gnt, a_d_done, a_i_gnt, a_i_done;
    logic        a_mem_en, a_mem_we, a_stall_if, a_stall_mem;
    logic [15:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [2:0]  a_dbg;

    logic        b_ld_gnt, b_ld_done, b_d_gnt, b_d_done, b_i_gnt, b_i_done;
    logic        b_mem_en, b_mem_we, b_stall_if, b_stall_mem;
    logic [15:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [2:0]  b_dbg;

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(2), .STARVE_MAX(3)) dut_a (
        .clk(clk), .reset(reset),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(a_ld_gnt), .ld_done(a_ld_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(a_d_gnt), .d_done(a_d_done),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(a_i_gnt), .i_done(a_i_done),
        .rdata(a_rdata), .mem_en(a_mem_en), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .stall_if(a_stall_if), .stall_mem(a_stall_mem), .o_dbg_state(a_dbg)
    );

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(1), .STARVE_MAX(3)) dut_b (
        .clk(clk), .reset(reset),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(b_ld_gnt), .ld_done(b_ld_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(b_d_gnt), .d_done(b_d_done),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(b_i_gnt), .i_done(b_i_done),
        .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .stall_if(b_stall_if), .stall_mem(b_stall_mem), .o_dbg_state(b_dbg)
    );

    // Memory models: read data is a fixed function of the issued address,
    // returned after the configured latency; DEAD when nothing was issued.
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return a ^ 16'hA5B5;
    endfunction

    logic [15:0] a_p1 = 16'hDEAD;
    logic [15:0] a_p2 = 16'hDEAD;
    logic [15:0] b_p1 = 16'hDEAD;
    always @(posedge clk) begin
        a_p1 <= a_mem_en ? mem_f(a_mem_addr) : 16'hDEAD;
        a_p2 <= a_p1;
        b_p1 <= b_mem_en ? mem_f(b_mem_addr) : 16'hDEAD;
    end
    assign a_mem_rdata = a_p2;
    assign b_mem_rdata = b_p1;

    // ---------------- scoreboard ----------------
    logic [35:0] exp_gnt_q[$];   // {gnt{ld,d,i}, mem_we, mem_addr, mem_wdata}
    logic [18:0] exp_done_q[$];  // {done{ld,d,i}, rdata}
    int errors = 0;
    int checks = 0;
    logic sel_b = 1'b0;          // which DUT the monitor and drivers follow
    int cyc = 0;
    int b_first = -1;
    int b_last = -1;
    int b_gnts = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] who_vec(input int who);
        case (who)
            0:       return 3'b100;
            1:       return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    task automatic push_access(input int who, input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata);
        exp_gnt_q.push_back({who_vec(who), (who == 2) ? 1'b0 : we, addr,
                             (who == 2) ? 16'h0000 : wdata});
        exp_done_q.push_back({who_vec(who), mem_f(addr)});
    endtask

    always @(negedge clk) begin
        logic [2:0]  g;
        logic [2:0]  dn;
        logic        en;
        logic        we;
        logic [15:0] ad;
        logic [15:0] wd;
        logic [15:0] rd;
        cyc++;
        if (!sel_b) begin
            g = {a_ld_gnt, a_d_gnt, a_i_gnt}; dn = {a_ld_done, a_d_done, a_i_done};
            en = a_mem_en; we = a_mem_we; ad = a_mem_addr; wd = a_mem_wdata; rd = a_rdata;
        end else begin
            g = {b_ld_gnt, b_d_gnt, b_i_gnt}; dn = {b_ld_done, b_d_done, b_i_done};
            en = b_mem_en; we = b_mem_we; ad = b_mem_addr; wd = b_mem_wdata; rd = b_rdata;
        end
        if (g != 3'b000 || en) begin
            if (sel_b) begin
                if (b_first < 0) b_first = cyc;
                b_last = cyc;
                b_gnts++;
            end
            if (exp_gnt_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_grant: got gnt=%b addr=%h expected no grant", g, ad);
            end else begin
                check("grant", {en, g, we, ad, wd}, {1'b1, exp_gnt_q.pop_front()});
            end
        end
        if (dn != 3'b000) begin
            if (exp_done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=%b rdata=%h expected no done", dn, rd);
            end else begin
                check("done", {dn, rd}, exp_done_q.pop_front());
            end
        end else begin
            check("rdata_idle", rd, 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int who, input logic rq, input logic we,
                         input logic [15:0] addr, input logic [15:0] wd);
        case (who)
            0:       begin ld_req = rq; ld_we = we; ld_addr = addr; ld_wdata = wd; end
            1:       begin d_req = rq; d_we = we; d_addr = addr; d_wdata = wd; end
            default: begin i_req = rq; i_addr = addr; end
        endcase
    endtask

    function automatic logic done_of(input int who);
        case (who)
            0:       return sel_b ? b_ld_done : a_ld_done;
            1:       return sel_b ? b_d_done : a_d_done;
            default: return sel_b ? b_i_done : a_i_done;
        endcase
    endfunction

    // n back-to-back accesses: req stays high, a new address follows each done.
    task automatic req_seq(input int who, input int n, input logic we,
                           input logic [15:0] a0, input logic [15:0] wd0);
        for (int k = 0; k < n; k++) begin
            bit got;
            got = 1'b0;
            @(posedge clk); #1;
            drive(who, 1'b1, we, a0 + 16'(k), wd0 + 16'(k));
            for (int c = 0; c < 50 && !got; c++) begin
                @(negedge clk);
                got = done_of(who);
            end
            check("done_within_budget", {32'(who), 31'd0, got}, {32'(who), 31'd0, 1'b1});
        end
        @(posedge clk); #1;
        drive(who, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int          who;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [2:0]  e_gnt;
        logic        e_we;
        logic [15:0] e_wdata;
        logic [15:0] e_rdata;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2, 1'b0, 16'h0010, 16'h7777, 3'b001, 1'b0, 16'h0000, 16'hA5A5};
        vecs[1] = '{1, 1'b1, 16'h0040, 16'h1234, 3'b010, 1'b1, 16'h1234, 16'hA5F5};
        vecs[2] = '{1, 1'b0, 16'h0041, 16'h0000, 3'b010, 1'b0, 16'h0000, 16'hA5F4};
        vecs[3] = '{0, 1'b1, 16'h0100, 16'hBEEF, 3'b100, 1'b1, 16'hBEEF, 16'hA4B5};
        vecs[4] = '{0, 1'b0, 16'hFFFF, 16'h0000, 3'b100, 1'b0, 16'h0000, 16'h5A4A};
        vecs[5] = '{2, 1'b1, 16'h8000, 16'h0000, 3'b001, 1'b0, 16'h0000, 16'h25B5};

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_a", {a_ld_gnt, a_ld_done, a_d_gnt, a_d_done, a_i_gnt, a_i_done,
                                  a_mem_en, a_mem_we, a_stall_if, a_stall_mem, a_dbg,
                                  a_rdata, a_mem_addr, a_mem_wdata}, 64'd0);
        check("reset_outputs_b", {b_ld_gnt, b_ld_done, b_d_gnt, b_d_done, b_i_gnt, b_i_done,
                                  b_mem_en, b_mem_we, b_stall_if, b_stall_mem, b_dbg,
                                  b_rdata, b_mem_addr, b_mem_wdata}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single fetch, cycle by cycle.
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 16'h0010;
        push_access(2, 1'b0, 16'h0010, 16'h0000);
        @(negedge clk);
        check("sf_issue", {a_i_gnt, a_mem_en, a_mem_we, a_mem_addr}, {3'b110, 16'h0010});
        check("sf_stall_t0", a_stall_if, 1);
        @(negedge clk);
        check("sf_stall_t1", {a_stall_if, a_i_done, a_mem_en}, 3'b100);
        @(negedge clk);
        check("sf_done_t2", {a_i_done, a_rdata, a_stall_if, a_stall_mem}, {1'b1, 16'hA5A5, 2'b00});
        @(posedge clk); #1;
        i_req = 1'b0;

        // Table of isolated accesses.
        for (int v = 0; v < 6; v++) begin
            exp_gnt_q.push_back({vecs[v].e_gnt, vecs[v].e_we, vecs[v].addr, vecs[v].e_wdata});
            exp_done_q.push_back({vecs[v].e_gnt, vecs[v].e_rdata});
            req_seq(vecs[v].who, 1, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            check("vec_queues_drained", exp_gnt_q.size() + exp_done_q.size(), 0);
        end

        // Collision: data write and fetch in the same cycle.
        push_access(1, 1'b1, 16'h0040, 16'h1234);
        push_access(2, 1'b0, 16'h0050, 16'h0000);
        fork
            req_seq(1, 1, 1'b1, 16'h0040, 16'h1234);
            req_seq(2, 1, 1'b0, 16'h0050, 16'h0000);
            begin : coll_chk
                bit seen;
                bit stall_ok;
                seen = 1'b0;
                stall_ok = 1'b1;
                @(posedge clk); #1;
                for (int c = 0; c < 20 && !seen; c++) begin
                    @(negedge clk);
                    if (!a_stall_if) stall_ok = 1'b0;
                    if (a_d_done) begin
                        seen = 1'b1;
                        check("coll_i_gnt_at_d_done", a_i_gnt, 1);
                    end
                end
                check("coll_d_done_seen", seen, 1);
                check("coll_stall_if_held", stall_ok, 1);
            end
        join
        check("coll_queues_drained", exp_gnt_q.size() + exp_done_q.size(), 0);

        // Starvation: loader and data keep the port busy while fetch waits;
        // after three data grants fetch must win over data.
        push_access(0, 1'b0, 16'h0200, 16'h0000); push_access(1, 1'b0, 16'h0300, 16'h0000);
        push_access(0, 1'b0, 16'h0201, 16'h0001); push_access(1, 1'b0, 16'h0301, 16'h0001);
        push_access(0, 1'b0, 16'h0202, 16'h0002); push_access(1, 1'b0, 16'h0302, 16'h0002);
        push_access(0, 1'b0, 16'h0203, 16'h0003); push_access(2, 1'b0, 16'h0400, 16'h0000);
        push_access(0, 1'b0, 16'h0204, 16'h0004); push_access(1, 1'b0, 16'h0303, 16'h0003);
        fork
            req_seq(0, 5, 1'b0, 16'h0200, 16'h0000);
            req_seq(1, 4, 1'b0, 16'h0300, 16'h0000);
            req_seq(2, 1, 1'b0, 16'h0400, 16'h0000);
        join
        check("starve_queues_drained", exp_gnt_q.size() + exp_done_q.size(), 0);

        // Loader priority with all three requesting from IDLE.
        push_access(0, 1'b1, 16'h0500, 16'hAAAA);
        push_access(1, 1'b1, 16'h0600, 16'h5555);
        push_access(2, 1'b0, 16'h0700, 16'h0000);
        fork
            req_seq(0, 1, 1'b1, 16'h0500, 16'hAAAA);
            req_seq(1, 1, 1'b1, 16'h0600, 16'h5555);
            req_seq(2, 1, 1'b0, 16'h0700, 16'h0000);
        join
        check("prio_queues_drained", exp_gnt_q.size() + exp_done_q.size(), 0);

        // Reset one cycle after a data grant: no done may follow.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0080; d_wdata = 16'h0000;
        exp_gnt_q.push_back({3'b010, 1'b0, 16'h0080, 16'h0000});
        @(negedge clk);
        check("rst_stall_mem", a_stall_mem, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {a_mem_en, a_d_gnt, a_d_done, a_dbg, a_rdata}, 0);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_quiet_after", {a_mem_en, a_d_done, a_dbg}, 0);
        push_access(1, 1'b0, 16'h0081, 16'h0000);
        req_seq(1, 1, 1'b0, 16'h0081, 16'h0000);
        check("rst_queues_drained", exp_gnt_q.size() + exp_done_q.size(), 0);

        // MEM_LAT = 1: data and fetch alternate every cycle.
        repeat (3) @(posedge clk);
        #1;
        sel_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_access(1, 1'b1, 16'h0900 + 16'(k), 16'h1100 + 16'(k));
            push_access(2, 1'b0, 16'h0A00 + 16'(k), 16'h0000);
        end
        fork
            req_seq(1, 4, 1'b1, 16'h0900, 16'h1100);
            req_seq(2, 4, 1'b0, 16'h0A00, 16'h0000);
        join
        check("alt_grant_count", b_gnts, 8);
        check("alt_no_gap", b_last - b_first, 7);
        check("alt_queues_drained", exp_gnt_q.size() + exp_done_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
